seq_alu: RTL and testbench

Parametrised, handshaked successor to the single-cycle datapath ALU. It keeps the 6-bit `ALUFun` operation encoding for add/sub, logic, shift and compare, registers every result, and adds iterative multiply and divide behind a valid/ready interface. It sits between the decode/operand stage and writeback in the multi-cycle core, which stalls on `in_ready`/`out_valid`.

---
 rtl/seq_alu.sv | 347 ++++++++++++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu -- registered, handshaked ALU with optional iterative multiply/divide.
//
// Keeps the 6-bit ALUFun encoding of the single-cycle datapath ALU (add/sub,
// logic, shift, compare) and registers every result behind a valid/ready pair.
// Single-cycle ops have latency 1. With SEQ_ALU_MULDIV_EN defined, MUL/MULH use
// a shift-add multiplier and DIV/REM a restoring divider, both one step per
// cycle on operand magnitudes with latency WIDTH+1. Without the macro those
// codes are reported as illegal and no iterative hardware is built.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  operation handshake; accept when both high at an edge
//   inA, inB            operands; shift amount is inA[SHW-1:0], value is inB
//   Sign                signed arithmetic / compare / mul / div
//   ALUFun              6-bit operation code
//   out_valid,out_ready result handshake; result held until taken
//   outZ                result
//   out_zf/vf/nf        zero/overflow/negative of add/sub/compare, else 0
//   out_err             illegal code or divide by zero
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             Sign,
    input  logic [5:0]       ALUFun,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] outZ,
    output logic             out_zf,
    output logic             out_vf,
    output logic             out_nf,
    output logic             out_err
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

`ifdef SEQ_ALU_MULDIV_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;
`endif

    typedef enum logic [1:0] {
        K_ILL = 2'd0,
        K_ONE = 2'd1,
        K_MUL = 2'd2,
        K_DIV = 2'd3
    } kind_t;

    state_t           state_r;
    state_t           state_nx_s;
    state_t           disp_s;
    kind_t            kind_s;
    logic             accept_s;
    logic [WIDTH-1:0] res_s;
    logic             zf_s, vf_s, nf_s;

    logic [WIDTH-1:0] outz_r;
    logic             zf_r, vf_r, nf_r, err_r;

    logic [WIDTH:0]   add_s, sub_s;
    logic             add_v_s, sub_v_s, sub_z_s, lt_s;
    logic             lez_s, ltz_s, gtz_s;
    logic [SHW-1:0]   shamt_s;

    assign in_ready  = (state_r == ST_IDLE) || ((state_r == ST_HOLD) && out_ready);
    assign accept_s  = in_valid && in_ready;
    assign out_valid = (state_r == ST_HOLD);
    assign outZ      = outz_r;
    assign out_zf    = zf_r;
    assign out_vf    = vf_r;
    assign out_nf    = nf_r;
    assign out_err   = err_r;

    // The extra top bit is the unsigned carry (add) or borrow (sub).
    assign add_s = {1'b0, inA} + {1'b0, inB};
    assign sub_s = {1'b0, inA} - {1'b0, inB};

    // Signed overflow: effective operand signs equal, result sign differs.
    assign add_v_s = Sign ? ((inA[WIDTH-1] == inB[WIDTH-1]) && (add_s[WIDTH-1] != inA[WIDTH-1]))
                          : add_s[WIDTH];
    assign sub_v_s = Sign ? ((inA[WIDTH-1] != inB[WIDTH-1]) && (sub_s[WIDTH-1] != inA[WIDTH-1]))
                          : sub_s[WIDTH];
    assign sub_z_s = (sub_s[WIDTH-1:0] == ZERO_W);
    // N xor V stays correct even when the subtraction itself overflows.
    assign lt_s    = Sign ? (sub_s[WIDTH-1] ^ sub_v_s) : sub_s[WIDTH];

    // Zero tests are always signed, regardless of Sign.
    assign ltz_s   = inA[WIDTH-1];
    assign lez_s   = inA[WIDTH-1] || (inA == ZERO_W);
    assign gtz_s   = !inA[WIDTH-1] && (inA != ZERO_W);
    assign shamt_s = inA[SHW-1:0];

    // Decode the operation class and compute the single-cycle result and flags.
    always_comb begin
        kind_s = K_ILL;
        res_s  = ZERO_W;
        zf_s   = 1'b0;
        vf_s   = 1'b0;
        nf_s   = 1'b0;
        case (ALUFun[5:4])
            2'b00: begin
                case (ALUFun[3:2])
                    2'b00: begin
                        kind_s = K_ONE;
                        if (ALUFun[0]) begin
                            res_s = sub_s[WIDTH-1:0];
                            vf_s  = sub_v_s;
                        end else begin
                            res_s = add_s[WIDTH-1:0];
                            vf_s  = add_v_s;
                        end
                        zf_s = (res_s == ZERO_W);
                        nf_s = res_s[WIDTH-1];
                    end
`ifdef SEQ_ALU_MULDIV_EN
                    2'b01:   kind_s = K_MUL;
                    2'b10:   kind_s = K_DIV;
`endif
                    default: kind_s = K_ILL;
                endcase
            end
            2'b01: begin
                kind_s = K_ONE;
                case (ALUFun[3:0])
                    4'b1000: res_s = inA & inB;
                    4'b1110: res_s = inA | inB;
                    4'b0110: res_s = inA ^ inB;
                    4'b0001: res_s = ~(inA | inB);
                    4'b1010: res_s = inA;
                    default: kind_s = K_ILL;
                endcase
            end
            2'b10: begin
                kind_s = K_ONE;
                case (ALUFun[1:0])
                    2'b00:   res_s = inB << shamt_s;
                    2'b01:   res_s = inB >> shamt_s;
                    2'b11:   res_s = $signed(inB) >>> shamt_s;
                    default: kind_s = K_ILL;
                endcase
            end
            2'b11: begin
                // Compare flags always reflect the internal A-B subtraction.
                kind_s = K_ONE;
                zf_s   = sub_z_s;
                nf_s   = sub_s[WIDTH-1];
                vf_s   = sub_v_s;
                case (ALUFun[3:1])
                    3'b000:  res_s = {{(WIDTH-1){1'b0}}, !sub_z_s};
                    3'b001:  res_s = {{(WIDTH-1){1'b0}}, sub_z_s};
                    3'b010:  res_s = {{(WIDTH-1){1'b0}}, lt_s};
                    3'b110:  res_s = {{(WIDTH-1){1'b0}}, lez_s};
                    3'b101:  res_s = {{(WIDTH-1){1'b0}}, ltz_s};
                    3'b111:  res_s = {{(WIDTH-1){1'b0}}, gtz_s};
                    default: begin
                        kind_s = K_ILL;
                        zf_s   = 1'b0;
                        nf_s   = 1'b0;
                        vf_s   = 1'b0;
                    end
                endcase
            end
            default: kind_s = K_ILL;
        endcase
    end

    // Target state for a newly accepted operation.
    always_comb begin
        disp_s = ST_HOLD;
        case (kind_s)
`ifdef SEQ_ALU_MULDIV_EN
            K_MUL:   disp_s = ST_MUL;
            K_DIV:   disp_s = ST_DIV;
`endif
            default: disp_s = ST_HOLD;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    // acc_r holds {partial, multiplier} for MUL and {remainder, quotient} for DIV.
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opnd_r;
    logic [WIDTH-1:0]   a_r;
    logic [SHW:0]       cnt_r;
    logic               neg_r, aneg_r, hi_r, dz_r;

    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_nx_s, prod_s;
    logic [WIDTH:0]     div_sh_s;
    logic               div_lt_s;
    logic [WIDTH-1:0]   div_df_s;
    logic [2*WIDTH-1:0] div_nx_s;
    logic [WIDTH-1:0]   quo_s, rem_s, md_res_s;
    logic               busy_s, fin_s;

    assign mag_a_s = (Sign && inA[WIDTH-1]) ? (ZERO_W - inA) : inA;
    assign mag_b_s = (Sign && inB[WIDTH-1]) ? (ZERO_W - inB) : inB;

    assign busy_s = (state_r == ST_MUL) || (state_r == ST_DIV);
    // One extra cycle after the last iteration applies sign fix-up and registers the result.
    assign fin_s  = busy_s && (cnt_r == CNT_LAST);

    assign mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                     + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    assign mul_nx_s  = {mul_sum_s, acc_r[WIDTH-1:1]};

    // Restoring step: the remainder is below the divisor, so a non-negative
    // trial difference always fits in WIDTH bits.
    assign div_sh_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    assign div_lt_s = (div_sh_s < {1'b0, opnd_r});
    assign div_df_s = div_sh_s[WIDTH-1:0] - opnd_r;
    assign div_nx_s = div_lt_s ? {div_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0}
                               : {div_df_s, acc_r[WIDTH-2:0], 1'b1};

    assign prod_s   = neg_r ? ({(2*WIDTH){1'b0}} - acc_r) : acc_r;
    assign quo_s    = dz_r ? {WIDTH{1'b1}}
                           : (neg_r ? (ZERO_W - acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0]);
    assign rem_s    = dz_r ? a_r
                           : (aneg_r ? (ZERO_W - acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH]);
    assign md_res_s = (state_r == ST_MUL) ? (hi_r ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0])
                                          : (hi_r ? rem_s : quo_s);

    // Latch magnitudes at accept, then run one multiply/divide step per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= {(2*WIDTH){1'b0}};
            opnd_r <= ZERO_W;
            a_r    <= ZERO_W;
            cnt_r  <= {(SHW+1){1'b0}};
            neg_r  <= 1'b0;
            aneg_r <= 1'b0;
            hi_r   <= 1'b0;
            dz_r   <= 1'b0;
        end else if (accept_s && ((kind_s == K_MUL) || (kind_s == K_DIV))) begin
            acc_r  <= {ZERO_W, (kind_s == K_MUL) ? mag_b_s : mag_a_s};
            opnd_r <= (kind_s == K_MUL) ? mag_a_s : mag_b_s;
            a_r    <= inA;
            cnt_r  <= {(SHW+1){1'b0}};
            neg_r  <= Sign && (inA[WIDTH-1] ^ inB[WIDTH-1]);
            aneg_r <= Sign && inA[WIDTH-1];
            hi_r   <= ALUFun[0];
            dz_r   <= (kind_s == K_DIV) && (inB == ZERO_W);
        end else if (fin_s) begin
            cnt_r  <= {(SHW+1){1'b0}};
        end else if (state_r == ST_MUL) begin
            acc_r  <= mul_nx_s;
            cnt_r  <= cnt_r + CNT_ONE;
        end else if (state_r == ST_DIV) begin
            acc_r  <= div_nx_s;
            cnt_r  <= cnt_r + CNT_ONE;
        end else begin
            cnt_r  <= cnt_r;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = disp_s;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (accept_s) begin
                    state_nx_s = disp_s;
                end else if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
`ifdef SEQ_ALU_MULDIV_EN
            ST_MUL, ST_DIV: begin
                if (cnt_r == CNT_LAST) begin
                    state_nx_s = ST_HOLD;
                end else begin
                    state_nx_s = state_r;
                end
            end
`endif
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Result and flag registers; held unchanged while waiting in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outz_r <= ZERO_W;
            zf_r   <= 1'b0;
            vf_r   <= 1'b0;
            nf_r   <= 1'b0;
            err_r  <= 1'b0;
        end else if (accept_s && ((kind_s == K_ONE) || (kind_s == K_ILL))) begin
            outz_r <= res_s;
            zf_r   <= zf_s;
            vf_r   <= vf_s;
            nf_r   <= nf_s;
            err_r  <= (kind_s == K_ILL);
        end
`ifdef SEQ_ALU_MULDIV_EN
        else if (fin_s) begin
            outz_r <= md_res_s;
            zf_r   <= 1'b0;
            vf_r   <= 1'b0;
            nf_r   <= 1'b0;
            err_r  <= dz_r;
        end
`endif
        else begin
            outz_r <= outz_r;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu -- self-checking bench for seq_alu (WIDTH=32).
// Directed cases plus randomized operations, checked against a behavioural
// model built from plain 64-bit arithmetic. Works with or without
// SEQ_ALU_MULDIV_EN defined.
module tb_seq_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inA, inB;
    logic        Sign;
    logic [5:0]  ALUFun;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] outZ;
    logic        out_zf, out_vf, out_nf, out_err;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inA(inA), .inB(inB), .Sign(Sign), .ALUFun(ALUFun),
        .out_valid(out_valid), .out_ready(out_ready), .outZ(outZ),
        .out_zf(out_zf), .out_vf(out_vf), .out_nf(out_nf), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] op_tab [0:24] = '{
        6'h00, 6'h01, 6'h18, 6'h1E, 6'h16, 6'h11, 6'h1A, 6'h20, 6'h21, 6'h23,
        6'h30, 6'h32, 6'h34, 6'h3C, 6'h3A, 6'h3E,
        6'h04, 6'h05, 6'h08, 6'h09,
        6'h0C, 6'h10, 6'h22, 6'h36, 6'h38
    };

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: result, flags, error and latency from the op rules.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [5:0] f, output logic [31:0] z, output logic zf,
                         output logic vf, output logic nf, output logic err,
                         output logic chkf, output int lat);
        longint ia, ib, d;
        logic [63:0] p;
        logic [31:0] df;
        logic ill;
        ia = longint'($signed(a));
        ib = longint'($signed(b));
        z = 32'h0; zf = 1'b0; vf = 1'b0; nf = 1'b0; err = 1'b0; chkf = 1'b1; lat = 1; ill = 1'b0;
        df = a - b;
        case (f[5:4])
            2'b00: begin
                case (f[3:2])
                    2'b00: begin
                        if (f[0] == 1'b0) begin
                            z = a + b;
                            d = ia + ib;
                            vf = s ? ((d > 64'sd2147483647) || (d < -64'sd2147483648))
                                   : (({32'h0, a} + {32'h0, b}) > 64'h0000_0000_FFFF_FFFF);
                        end else begin
                            z = a - b;
                            d = ia - ib;
                            vf = s ? ((d > 64'sd2147483647) || (d < -64'sd2147483648)) : (a < b);
                        end
                        zf = (z == 32'h0);
                        nf = z[31];
                    end
`ifdef SEQ_ALU_MULDIV_EN
                    2'b01: begin
                        lat = 33;
                        if (s) p = ia * ib;
                        else p = {32'h0, a} * {32'h0, b};
                        z = f[0] ? p[63:32] : p[31:0];
                    end
                    2'b10: begin
                        lat = 33;
                        if (b == 32'h0) begin
                            z = f[0] ? a : 32'hFFFF_FFFF;
                            err = 1'b1;
                        end else if (s) begin
                            p = f[0] ? (ia % ib) : (ia / ib);
                            z = p[31:0];
                        end else begin
                            z = f[0] ? (a % b) : (a / b);
                        end
                    end
`endif
                    default: ill = 1'b1;
                endcase
            end
            2'b01: begin
                case (f[3:0])
                    4'b1000: z = a & b;
                    4'b1110: z = a | b;
                    4'b0110: z = a ^ b;
                    4'b0001: z = ~(a | b);
                    4'b1010: z = a;
                    default: ill = 1'b1;
                endcase
            end
            2'b10: begin
                case (f[1:0])
                    2'b00: z = b << a[4:0];
                    2'b01: z = b >> a[4:0];
                    2'b11: z = $signed(b) >>> a[4:0];
                    default: ill = 1'b1;
                endcase
            end
            default: begin
                zf = (a == b);
                nf = df[31];
                d = ia - ib;
                vf = s ? ((d > 64'sd2147483647) || (d < -64'sd2147483648)) : (a < b);
                case (f[3:1])
                    3'b000: z = {31'h0, a != b};
                    3'b001: z = {31'h0, a == b};
                    3'b010: z = {31'h0, s ? (ia < ib) : (a < b)};
                    3'b110: begin z = {31'h0, ia <= 0}; chkf = 1'b0; end
                    3'b101: begin z = {31'h0, ia < 0};  chkf = 1'b0; end
                    3'b111: begin z = {31'h0, ia > 0};  chkf = 1'b0; end
                    default: ill = 1'b1;
                endcase
            end
        endcase
        if (ill) begin
            z = 32'h0; zf = 1'b0; vf = 1'b0; nf = 1'b0; err = 1'b1; chkf = 1'b1; lat = 1;
        end
        if (lat > 1) begin
            zf = 1'b0; vf = 1'b0; nf = 1'b0;
        end
    endtask

    // One op from IDLE: accept, wait for result, hold it, then consume it.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [5:0] f, input int hold, input string tag);
        logic [31:0] ez;
        logic ezf, evf, enf, eerr, chkf, rdy_ok;
        int elat, lat;
        model(a, b, s, f, ez, ezf, evf, enf, eerr, chkf, elat);
        @(negedge clk);
        chk({tag, ".in_ready_idle"}, in_ready, 1'b1);
        in_valid = 1'b1; inA = a; inB = b; Sign = s; ALUFun = f; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; inA = $urandom; inB = $urandom; Sign = 1'($urandom); ALUFun = 6'($urandom);
        lat = 1;
        rdy_ok = 1'b1;
        while ((out_valid !== 1'b1) && (lat < 200)) begin
            if (in_ready !== 1'b0) rdy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, lat, elat);
        if (elat > 1) chk({tag, ".busy_in_ready"}, rdy_ok, 1'b1);
        chk({tag, ".outZ"}, outZ, ez);
        chk({tag, ".err"}, out_err, eerr);
        if (chkf) begin
            chk({tag, ".zf"}, out_zf, ezf);
            chk({tag, ".vf"}, out_vf, evf);
            chk({tag, ".nf"}, out_nf, enf);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold_outZ"}, outZ, ez);
            chk({tag, ".hold_valid"}, out_valid, 1'b1);
            chk({tag, ".hold_in_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".consumed"}, out_valid, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 40)) - 32'd20;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] qa [$];
        logic [31:0] qb [$];
        logic [31:0] qz [$];
        logic [31:0] ez, ra, rb;
        logic ezf, evf, enf, eerr, chkf, rs;
        logic [5:0] rf;
        int elat;

        rst_n = 1'b0; in_valid = 1'b0; inA = 32'h0; inB = 32'h0;
        Sign = 1'b0; ALUFun = 6'h0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.out_valid", out_valid, 1'b0);
        chk("reset.outZ", outZ, 32'h0);
        chk("reset.flags", {out_zf, out_vf, out_nf, out_err}, 4'h0);
        chk("reset.in_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 6'h00, 0, "add_ovf");
        run_op(32'h0000_0004, 32'h8000_0000, 1'b0, 6'h23, 0, "sra");
        run_op(32'h0000_0004, 32'h8000_0000, 1'b0, 6'h21, 0, "srl");
        run_op(32'hFFFF_FFFB, 32'h0000_0003, 1'b1, 6'h34, 0, "lt_s");
        run_op(32'hFFFF_FFFB, 32'h0000_0003, 1'b0, 6'h34, 0, "lt_u");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 6'h34, 0, "lt_min");
        run_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 6'h04, 5, "mul");
        run_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 6'h05, 0, "mulh");
        run_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 6'h08, 0, "div");
        run_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 6'h09, 0, "rem");
        run_op(32'h0000_0007, 32'h0000_0000, 1'b1, 6'h08, 0, "div0");
        run_op(32'h0000_0007, 32'h0000_0000, 1'b1, 6'h09, 0, "rem0");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 6'h08, 0, "div_min");
        run_op(32'h1234_5678, 32'h0F0F_F0F0, 1'b0, 6'h38, 2, "illegal");
        run_op(32'h0000_0005, 32'h0000_0005, 1'b0, 6'h01, 0, "sub_zero");

        // Back-to-back single-cycle ops with out_ready held high.
        for (int i = 0; i < 8; i++) begin
            qa.push_back(pick());
            qb.push_back(pick());
            model(qa[i], qb[i], 1'b1, op_tab[i % 16], ez, ezf, evf, enf, eerr, chkf, elat);
            qz.push_back(ez);
        end
        @(negedge clk);
        in_valid = 1'b1; inA = qa[0]; inB = qb[0]; Sign = 1'b1; ALUFun = op_tab[0]; out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("b2b.valid", out_valid, 1'b1);
            chk("b2b.outZ", outZ, qz[i-1]);
            chk("b2b.in_ready", in_ready, 1'b1);
            if (i < 8) begin
                inA = qa[i]; inB = qb[i]; ALUFun = op_tab[i % 16];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b.drained", out_valid, 1'b0);

        // Reset pulse during a multiply (or its illegal-code result when disabled).
        @(negedge clk);
        in_valid = 1'b1; inA = 32'hFFFF_FFFD; inB = 32'h0000_0007; Sign = 1'b1; ALUFun = 6'h04;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.valid", out_valid, 1'b0);
        chk("rst_mid.outZ", outZ, 32'h0);
        chk("rst_mid.flags", {out_zf, out_vf, out_nf, out_err}, 4'h0);
        chk("rst_mid.in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h0000_0006, 32'h0000_0007, 1'b0, 6'h04, 0, "after_rst");

        // Randomized operations against the model.
        for (int n = 0; n < 60; n++) begin
            ra = pick();
            rb = pick();
            rs = 1'($urandom);
            rf = op_tab[$urandom_range(0, 24)];
            run_op(ra, rb, rs, rf, $urandom_range(0, 2), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
